// File: rtl/keypad_pkg.sv
// Shared types and constant tables for the 4x4 matrix keypad scanner.
package keypad_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      PRESS_DB   = 2'd1,
      PRESSED    = 2'd2,
      RELEASE_DB = 2'd3
   } kp_state_t;

   typedef enum logic [1:0] {
      SCAN_NONE   = 2'd0,
      SCAN_SINGLE = 2'd1,
      SCAN_MULTI  = 2'd2
   } scan_kind_t;

   // Nibble {row,col} holds the key value; row-major, row 0 / col 0 in the LSBs.
   localparam logic [63:0] KEY_MAP   = 64'hDEF0_C987_B654_A321;
   localparam logic [15:0] COL_DRIVE = 16'h7BDE;

   function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
      return KEY_MAP[{row, col, 2'b00} +: 4];
   endfunction

   function automatic logic [3:0] col_drive(input logic [1:0] idx);
      return COL_DRIVE[{idx, 2'b00} +: 4];
   endfunction

endpackage

// File: rtl/keypad_scanner_row_sync.sv
// Two-flop synchronizer for the keypad row sense lines; resets to idle (all ones).
module row_sync (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] async_rows,
   output logic [3:0] sync_rows
);

   logic [3:0] meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta      <= 4'hF;
         sync_rows <= 4'hF;
      end else begin
         meta      <= async_rows;
         sync_rows <= meta;
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// Column-multiplexed 4x4 keypad scanner with press/release debounce.
//   state      | meaning
//   IDLE       | no key accepted, waiting for a single key
//   PRESS_DB   | candidate key seen, counting agreeing scans
//   PRESSED    | key accepted and held
//   RELEASE_DB | accepted key missing, counting release scans
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_TICKS     = 100000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic [3:0] col_n,
   input  logic [3:0] row_n,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   localparam int TW = $clog2(SCAN_TICKS);
   localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);
   localparam logic [SW-1:0] DB_LAST   = SW'(DEBOUNCE_SCANS);

   logic [3:0]    row_s;
   logic [TW-1:0] tick;
   logic [1:0]    col_idx;
   logic          tick_last, scan_done;

   logic [1:0]    acc_cnt;
   logic [3:0]    acc_code;
   logic [2:0]    col_hits, acc_sum;
   logic [1:0]    hit_row;
   logic [3:0]    scan_code;
   scan_kind_t    scan_kind;

   kp_state_t     state, state_nx;
   logic [SW-1:0] stab, stab_nx, stab_inc;
   logic [3:0]    cand, cand_nx, code_nx;
   logic          valid_nx, held_nx;

   row_sync u_row_sync (
      .clk        (clk),
      .rst_n      (rst_n),
      .async_rows (row_n),
      .sync_rows  (row_s)
   );

   assign tick_last = (tick == TICK_LAST);
   assign scan_done = tick_last && (col_idx == 2'd3);
   assign col_n     = col_drive(col_idx);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick    <= '0;
         col_idx <= 2'd0;
      end else if (tick_last) begin
         tick    <= '0;
         col_idx <= col_idx + 2'd1;
      end else begin
         tick    <= tick + TW'(1);
      end
   end

   always_comb begin
      col_hits = 3'd0;
      hit_row  = 2'd0;
      for (int r = 3; r >= 0; r--) begin
         if (!row_s[r]) begin
            col_hits = col_hits + 3'd1;
            hit_row  = 2'(r);
         end
      end
   end

   // The first hit of a scan names the key; later hits only matter as a count.
   assign acc_sum   = {1'b0, acc_cnt} + col_hits;
   assign scan_code = (acc_cnt == 2'd0) ? key_lookup(hit_row, col_idx) : acc_code;

   always_comb begin
      scan_kind = SCAN_NONE;
      if (acc_sum == 3'd1)
         scan_kind = SCAN_SINGLE;
      else if (acc_sum >= 3'd2)
         scan_kind = SCAN_MULTI;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_cnt  <= 2'd0;
         acc_code <= 4'h0;
      end else if (tick_last) begin
         if (col_idx == 2'd3) begin
            acc_cnt  <= 2'd0;
            acc_code <= 4'h0;
         end else begin
            acc_cnt  <= (acc_sum >= 3'd2) ? 2'd2 : acc_sum[1:0];
            acc_code <= scan_code;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         stab      <= '0;
         cand      <= 4'h0;
         key_code  <= 4'h0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
      end else begin
         state     <= state_nx;
         stab      <= stab_nx;
         cand      <= cand_nx;
         key_code  <= code_nx;
         key_valid <= valid_nx;
         key_held  <= held_nx;
      end
   end

   assign stab_inc = stab + SW'(1);

   always_comb begin
      state_nx = state;
      stab_nx  = stab;
      cand_nx  = cand;
      code_nx  = key_code;
      valid_nx = 1'b0;
      held_nx  = key_held;
      if (scan_done) begin
         case (state)
            IDLE: begin
               if (scan_kind == SCAN_SINGLE) begin
                  cand_nx = scan_code;
                  stab_nx = SW'(1);
                  if (DEBOUNCE_SCANS == 1) begin
                     state_nx = PRESSED;
                     code_nx  = scan_code;
                     valid_nx = 1'b1;
                     held_nx  = 1'b1;
                  end else begin
                     state_nx = PRESS_DB;
                  end
               end
            end
            PRESS_DB: begin
               if (scan_kind == SCAN_SINGLE) begin
                  if (scan_code == cand) begin
                     stab_nx = stab_inc;
                     if (stab_inc == DB_LAST) begin
                        state_nx = PRESSED;
                        code_nx  = cand;
                        valid_nx = 1'b1;
                        held_nx  = 1'b1;
                     end
                  end else begin
                     cand_nx = scan_code;
                     stab_nx = SW'(1);
                  end
               end else if (scan_kind == SCAN_MULTI) begin
                  stab_nx = '0;
               end else begin
                  state_nx = IDLE;
                  stab_nx  = '0;
               end
            end
            PRESSED: begin
               if (!(scan_kind == SCAN_MULTI ||
                     (scan_kind == SCAN_SINGLE && scan_code == key_code))) begin
                  // A single agreeing scan already satisfies a one-scan debounce.
                  if (DEBOUNCE_SCANS == 1) begin
                     state_nx = IDLE;
                     stab_nx  = '0;
                     held_nx  = 1'b0;
                  end else begin
                     state_nx = RELEASE_DB;
                     stab_nx  = SW'(1);
                  end
               end
            end
            RELEASE_DB: begin
               if (scan_kind == SCAN_SINGLE && scan_code == key_code) begin
                  state_nx = PRESSED;
                  stab_nx  = '0;
               end else if (scan_kind != SCAN_MULTI) begin
                  stab_nx = stab_inc;
                  if (stab_inc == DB_LAST) begin
                     state_nx = IDLE;
                     stab_nx  = '0;
                     held_nx  = 1'b0;
                  end
               end
            end
            default: begin
               state_nx = IDLE;
               stab_nx  = '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a behavioural keypad matrix answers the column drive.
module tb_keypad_scanner;

   logic       clk;
   logic       rst_n;
   logic [3:0] col_n;
   logic [3:0] row_n;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;

   logic [15:0] keys;
   int          cyc;
   int          pulses;
   int          last_cyc;
   int          checks;
   int          errors;

   keypad_scanner #(
      .SCAN_TICKS     (4),
      .DEBOUNCE_SCANS (2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .col_n     (col_n),
      .row_n     (row_n),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_held  (key_held)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Key bit index is row*4+col; a pressed key pulls its row low while its column is driven.
   always_comb begin
      row_n = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4+c] && !col_n[c])
               row_n[r] = 1'b0;
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   always @(posedge clk) begin
      if (rst_n && key_valid) begin
         pulses   <= pulses + 1;
         last_cyc <= cyc;
      end
   end

   function automatic logic [3:0] exp_col(input int k);
      case ((k / 4) % 4)
         0:       return 4'b1110;
         1:       return 4'b1101;
         2:       return 4'b1011;
         default: return 4'b0111;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run_to(input int c);
      int guard;
      guard = 0;
      while (cyc != c && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      check("cycle_reached", cyc, c);
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      pulses   = 0;
      last_cyc = -1;
      keys     = 16'h0000;
      rst_n    = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_col_n", col_n, 4'b1110);
      check("rst_key_code", key_code, 4'h0);
      check("rst_key_valid", key_valid, 1'b0);
      check("rst_key_held", key_held, 1'b0);
      rst_n = 1'b1;

      // Idle rows: five full scans of column rotation
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         check("idle_col_n", col_n, exp_col(cyc));
      end
      check("idle_pulses", pulses, 0);
      check("idle_key_code", key_code, 4'h0);

      // Key 6 (row1, col2)
      keys = 16'h0040;
      run_to(111);
      check("k6_pre_valid", key_valid, 1'b0);
      check("k6_pre_held", key_held, 1'b0);
      run_to(112);
      check("k6_valid", key_valid, 1'b1);
      check("k6_code", key_code, 4'h6);
      check("k6_held", key_held, 1'b1);
      run_to(113);
      check("k6_valid_single", key_valid, 1'b0);
      run_to(144);
      check("k6_pulses", pulses, 1);
      check("k6_strobe_cycle", last_cyc, 112);

      // Short release then re-press: back to PRESSED without a strobe
      keys = 16'h0000;
      run_to(160);
      check("short_rel_held", key_held, 1'b1);
      keys = 16'h0040;
      run_to(176);
      keys = 16'h0000;
      run_to(180);
      check("repress_pulses", pulses, 1);
      check("repress_held", key_held, 1'b1);
      run_to(207);
      check("rel_held_before", key_held, 1'b1);
      run_to(208);
      check("rel_held_drop", key_held, 1'b0);
      check("rel_code_kept", key_code, 4'h6);

      // Bouncing A (row0, col3) in alternate scans, then stable
      keys = 16'h0008;
      run_to(224);
      keys = 16'h0000;
      run_to(240);
      keys = 16'h0008;
      run_to(256);
      keys = 16'h0000;
      run_to(272);
      keys = 16'h0008;
      run_to(288);
      check("bounce_pulses", pulses, 1);
      run_to(303);
      check("bounce_code_kept", key_code, 4'h6);
      run_to(304);
      check("kA_valid", key_valid, 1'b1);
      check("kA_code", key_code, 4'hA);
      keys = 16'h0000;
      run_to(306);
      check("kA_pulses", pulses, 2);
      check("kA_strobe_cycle", last_cyc, 304);
      run_to(336);
      check("kA_released", key_held, 1'b0);

      // Keys 1 and 5 together, then 5 released
      keys = 16'h0021;
      run_to(400);
      check("multi_pulses", pulses, 2);
      check("multi_held", key_held, 1'b0);
      check("multi_code", key_code, 4'hA);
      keys = 16'h0001;
      run_to(431);
      check("k1_pre_valid", key_valid, 1'b0);
      run_to(432);
      check("k1_valid", key_valid, 1'b1);
      check("k1_code", key_code, 4'h1);
      check("k1_held", key_held, 1'b1);
      keys = 16'h0000;
      run_to(464);
      check("k1_released", key_held, 1'b0);

      // Key 9 (row2, col2), reset in PRESS_DB while column 2 is driven
      keys = 16'h0400;
      run_to(489);
      check("pre_rst_col_n", col_n, 4'b1011);
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_col_n", col_n, 4'b1110);
      check("mid_rst_code", key_code, 4'h0);
      check("mid_rst_valid", key_valid, 1'b0);
      check("mid_rst_held", key_held, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      run_to(16);
      check("post_rst_pulses", pulses, 3);
      run_to(31);
      check("post_rst_pre_valid", key_valid, 1'b0);
      check("post_rst_pre_code", key_code, 4'h0);
      run_to(32);
      check("k9_valid", key_valid, 1'b1);
      check("k9_code", key_code, 4'h9);
      check("k9_held", key_held, 1'b1);
      run_to(34);
      check("k9_pulses", pulses, 4);
      check("k9_strobe_cycle", last_cyc, 32);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
